ps2_scancode_ctrl: RTL

//  Sequencer between the PS/2 byte receiver and the consumer logic (display, ASCII LUT).

---
 rtl/ps2_scancode_ctrl_pkg.sv | 32 +++
 rtl/ps2_scancode_ctrl_if.sv | 30 +++
 rtl/ps2_scancode_ctrl_fifo.sv | 53 +++++
 rtl/ps2_scancode_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/ps2_scancode_ctrl_pkg.sv
// Shared types and constants for the PS/2 scan-code sequencer: FSM states,
// set-2 prefix bytes, non-key byte list and the packed key-event record.
package ps2_pkg;

   typedef enum logic [1:0] {IDLE, E0, F0, E0F0} ps2_state_t;

   localparam logic [7:0] PS2_E0  = 8'hE0;
   localparam logic [7:0] PS2_BRK = 8'hF0;

   // Keyboard status/response bytes that never belong to a key sequence.
   localparam int NONKEY_N = 7;
   localparam logic [NONKEY_N*8-1:0] NONKEY_BYTES =
      {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

   localparam int EVENT_W = $bits(ps2_event_t);

   function automatic logic is_nonkey(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NONKEY_N; i++) begin
         if (NONKEY_BYTES[i*8 +: 8] == b) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/ps2_scancode_ctrl_if.sv
// Byte-in / event-out bundle of the scan-code sequencer; the slave side is the
// sequencer, the master side is whoever feeds bytes and consumes events.
interface ps2_scancode_ctrl_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       key_held;
   logic [8:0] held_code;
   logic [7:0] press_count;
   logic       overflow;
   logic       clr_ovf;

   modport slave (
      input  rx_data, rx_valid, ev_ready, clr_ovf,
      output ev_valid, ev_code, ev_ext, ev_break,
             key_held, held_code, press_count, overflow
   );

   modport master (
      output rx_data, rx_valid, ev_ready, clr_ovf,
      input  ev_valid, ev_code, ev_ext, ev_break,
             key_held, held_code, press_count, overflow
   );

endinterface

// File: rtl/ps2_scancode_ctrl_fifo.sv
// First-word-fall-through event FIFO with extra-MSB pointers; the head is
// forced to zero while empty so the output is clean straight out of reset.
module ps2_event_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   output logic             o_full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_empty;
   logic             w_full;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign w_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop & ~w_empty;
   assign w_push_ok = i_push & (~w_full | w_pop_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array is deliberately left out of reset; the pointers
   // alone define which entries are live, so flushing them empties the FIFO.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign o_valid = ~w_empty;
   assign o_full  = w_full;

endmodule

// File: rtl/ps2_scancode_ctrl.sv
// Assembles set-2 scan-code bytes into press/release events, tracks the held
// key and distinct-press count, and queues events for a valid/ready consumer.
module ps2_scancode_ctrl
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic               clk,
   input  logic               resetn,
   ps2_scancode_ctrl_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   ps2_state_t  r_state;
   ps2_state_t  w_state_nxt;
   logic [TW-1:0] r_timer;
   logic        w_timeout;
   logic        w_emit;
   ps2_event_t  w_event;
   ps2_event_t  w_head;
   logic        w_ev_valid;
   logic        w_full;
   logic        w_pop;
   logic        w_drop;
   logic        w_same_key;
   logic        r_key_held;
   logic [8:0]  r_held_code;
   logic [7:0]  r_press_count;
   logic        r_overflow;

   assign w_timeout = (r_state != IDLE) && (r_timer == TIMER_LAST);

   // NOTE: state and every other register update with non-blocking assignments
   // so all flops sample the same pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_event     = '0;
      if (bus.rx_valid) begin
         if (is_nonkey(bus.rx_data)) begin
            w_state_nxt = IDLE;
         end else if (bus.rx_data == PS2_E0) begin
            w_state_nxt = (r_state == F0 || r_state == E0F0) ? E0F0 : E0;
         end else if (bus.rx_data == PS2_BRK) begin
            w_state_nxt = (r_state == E0 || r_state == E0F0) ? E0F0 : F0;
         end else begin
            w_emit       = 1'b1;
            w_event.ext  = (r_state == E0) || (r_state == E0F0);
            w_event.brk  = (r_state == F0) || (r_state == E0F0);
            w_event.code = bus.rx_data;
            w_state_nxt  = IDLE;
         end
      end else if (w_timeout) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                r_timer <= '0;
      else if (bus.rx_valid || r_state == IDLE || w_timeout) r_timer <= '0;
      else                                        r_timer <= r_timer + TW'(1);
   end

   assign w_same_key = r_key_held && ({w_event.ext, w_event.code} == r_held_code);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_key_held    <= 1'b0;
         r_held_code   <= '0;
         r_press_count <= '0;
      end else if (w_emit) begin
         if (!w_event.brk) begin
            if (!w_same_key) begin
               r_key_held    <= 1'b1;
               r_held_code   <= {w_event.ext, w_event.code};
               r_press_count <= r_press_count + 8'd1;
            end
         end else if (w_same_key) begin
            r_key_held <= 1'b0;
         end
      end
   end

   assign w_pop  = bus.ev_ready & w_ev_valid;
   assign w_drop = w_emit & w_full & ~w_pop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          r_overflow <= 1'b0;
      else if (w_drop)      r_overflow <= 1'b1;
      else if (bus.clr_ovf) r_overflow <= 1'b0;
   end

   ps2_event_fifo #(
      .WIDTH (EVENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (resetn),
      .i_push  (w_emit),
      .i_data  (w_event),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_valid (w_ev_valid),
      .o_full  (w_full)
   );

   assign bus.ev_valid    = w_ev_valid;
   assign bus.ev_code     = w_head.code;
   assign bus.ev_ext      = w_head.ext;
   assign bus.ev_break    = w_head.brk;
   assign bus.key_held    = r_key_held;
   assign bus.held_code   = r_held_code;
   assign bus.press_count = r_press_count;
   assign bus.overflow    = r_overflow;

endmodule
